soc_system_ok_burst_reader: RTL and testbench
=============================================

// Module: soc_system_ok_burst_reader
// PURPOSE
//  Consumer of the 1-bit software "OK" PIO level: a rising edge on ok_in launches a burst of
//  BURST_LEN words popped from a show-ahead FIFO and presented on an Avalon-ST source.
//  Sits between the HPS-controlled OK PIO and the FPGA datapath in the FIFO design; progress is
//  readable over a small Avalon-MM slave so software knows when to drop OK and re-arm.
// PARAMETERS
//  DATA_W     32    FIFO / stream data width
//  BURST_LEN  16    words per burst, 1..2**CNT_W-1
//  CNT_W      16    width of word counter and status count field
//  TIMEOUT    1024  stall cycles before abort (used only with OKB_TIMEOUT_EN)
// PORTS
//  clk           in   1       system clock
//  reset_n       in   1       synchronous, active-low reset
//  ok_in         in   1       level from OK PIO out_port
//  fifo_q        in   DATA_W  show-ahead FIFO head word
//  fifo_empty    in   1       FIFO empty
//  fifo_rdreq    out  1       pop strobe, one word per asserted cycle
//  st_data       out  DATA_W  stream data
//  st_valid      out  1       stream valid
//  st_ready      in   1       stream ready
//  address       in   2       Avalon-MM slave address
//  chipselect    in   1       slave select
//  write_n       in   1       slave write, active-low
//  writedata     in   32      slave write data
//  readdata      out  32      slave read data, combinational from address
//  done          out  1       burst complete, held until ok_in low
// BEHAVIOUR
//  - Reset (reset_n==0 at clk edge): state IDLE, st_valid=0, st_data=0, fifo_rdreq=0, done=0,
//    count=0, ok_d=0, timeout flag=0. Reset mid-burst abandons it; an in-flight word is dropped.
//  - ok_d registers ok_in; start = ok_in & ~ok_d (single-cycle edge detect).
//  - States: IDLE -start-> STREAM; STREAM -(count==BURST_LEN)-> DONE; DONE -(~ok_in)-> IDLE.
//    ok_in high while in IDLE without a fresh edge does NOT start a burst.
//  - STREAM: fifo_rdreq = ~fifo_empty & (~st_valid | st_ready) & (issued < BURST_LEN), combinational;
//    on pop, st_data<=fifo_q, st_valid<=1 next cycle (1-cycle latency FIFO head -> stream).
//    st_valid held with st_data stable until st_ready; st_valid falls on accept with no new pop.
//    Full throughput: back-to-back pop+accept every cycle when FIFO non-empty and st_ready=1.
//  - count increments on st_valid&st_ready; DONE entered the cycle after final accept; never exceeds BURST_LEN.
//  - ok_in falling during STREAM: burst continues to completion, then DONE exits to IDLE immediately.
//  - done = (state==DONE). fifo_rdreq never asserted in IDLE or DONE.
//  - Slave regs (read): 0 = {29'b0, timeout, done, busy}; 1 = {zero-ext count}; 2 = BURST_LEN; 3 = 0.
//    Write to address 0 with writedata[0]=1 in DONE: clear count/done and return to IDLE (soft re-arm).
//    All other writes ignored.
// CONFIGURATION
//  OKB_TIMEOUT_EN defined: stall counter increments each STREAM cycle with no accept, clears on accept;
//   reaching TIMEOUT -> DONE with timeout=1 (cleared on next start). Undefined: no counter,
//   timeout bit reads 0, STREAM waits indefinitely for FIFO data / st_ready.
// STRUCTURE
//  - Package soc_system_okb_pkg: state enum (IDLE, STREAM, DONE), register address constants,
//    status bit positions.
//  - One sub-module: soc_system_okb_skid (1-entry output register with valid/ready handling).
//    FSM, counters, and slave decode live in the top.
// TESTING
//  1. Reset, ok_in 0->1, FIFO holds 16 words, st_ready=1 -> 16 beats in order, done=1 after last; reg1 reads 16.
//  2. st_ready toggled 1,0,0,1... -> no lost/duplicated words; st_data stable while valid & ~ready.
//  3. FIFO empty for 20 cycles mid-burst -> fifo_rdreq=0, stream stalls, resumes, still exactly 16 beats.
//  4. ok_in held high after DONE, no write -> no second burst; ok_in 0->1 again -> new burst starts.
//  5. reset_n low at beat 7 -> all outputs zero next cycle, reg1 reads 0, FIFO not popped further.
//  6. OKB_TIMEOUT_EN, TIMEOUT=8, FIFO empty after 3 words -> DONE with reg0=0b110 after 8 stall cycles.

Source files
------------

// File: rtl/soc_system_okb_pkg.sv
// Shared types and constants for the OK-triggered burst reader.
// Optional stall timeout is enabled with the OKB_TIMEOUT_EN macro.
package soc_system_okb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } okb_state_e;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_BURST  = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int unsigned STAT_BUSY_BIT    = 0;
    localparam int unsigned STAT_DONE_BIT    = 1;
    localparam int unsigned STAT_TIMEOUT_BIT = 2;

endpackage

// File: rtl/soc_system_okb_skid.sv
// One-entry stream output register: captures a popped FIFO word and holds it
// stable until the sink accepts; flush discards any held word.
module soc_system_okb_skid #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            // A load in the same cycle as an accept replaces the outgoing word.
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/soc_system_ok_burst_reader.sv
// Rising edge on ok_in streams BURST_LEN FIFO words out on Avalon-ST; progress via Avalon-MM.
// Define OKB_TIMEOUT_EN to abort a burst after TIMEOUT cycles without an accepted beat.
module soc_system_ok_burst_reader
    import soc_system_okb_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ok_in,
    input  logic [DATA_W-1:0] fifo_q,
    input  logic              fifo_empty,
    output logic              fifo_rdreq,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              done
);

    localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

    okb_state_e       state_q, state_d;
    logic             ok_d_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic             timeout_q, timeout_d;

    logic start, accept, timeout_hit, soft_rearm, busy;

    assign start      = ok_in & ~ok_d_q;
    assign accept     = st_valid & st_ready & (state_q == STREAM);
    assign soft_rearm = chipselect & ~write_n & (address == REG_STATUS) & writedata[0];
    assign busy       = (state_q == STREAM);
    assign done       = (state_q == DONE);

`ifdef OKB_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_q, stall_d;

    assign timeout_hit = (state_q == STREAM) & ~accept & (stall_q == STALL_W'(TIMEOUT - 1));

    always_comb begin
        stall_d = '0;
        if ((state_q == STREAM) && !accept && !timeout_hit)
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) stall_q <= '0;
        else          stall_q <= stall_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    // Gated by reset_n so a reset cycle never pops a word that would be lost.
    assign fifo_rdreq = reset_n & (state_q == STREAM) & ~fifo_empty
                      & (~st_valid | st_ready) & (issued_q < BURST_LEN_C) & ~timeout_hit;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        issued_d  = issued_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = STREAM;
                    count_d   = '0;
                    issued_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            STREAM: begin
                if (fifo_rdreq) issued_d = issued_q + 1'b1;
                if (accept)     count_d  = count_q + 1'b1;
                if (count_d == BURST_LEN_C) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                if (soft_rearm) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (!ok_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ok_d_q    <= 1'b0;
            count_q   <= '0;
            issued_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ok_d_q    <= ok_in;
            count_q   <= count_d;
            issued_q  <= issued_d;
            timeout_q <= timeout_d;
        end
    end

    soc_system_okb_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (timeout_hit),
        .load      (fifo_rdreq),
        .load_data (fifo_q),
        .ready     (st_ready),
        .valid     (st_valid),
        .data      (st_data)
    );

    logic unused_wdata;
    assign unused_wdata = ^writedata[31:1];

    always_comb begin
        readdata = '0;
        case (address)
            REG_STATUS: begin
                readdata[STAT_BUSY_BIT]    = busy;
                readdata[STAT_DONE_BIT]    = done;
                readdata[STAT_TIMEOUT_BIT] = timeout_q;
            end
            REG_COUNT: readdata = 32'(count_q);
            REG_BURST: readdata = 32'(BURST_LEN);
            default:   readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_soc_system_ok_burst_reader.sv
// Directed bench for soc_system_ok_burst_reader with a show-ahead FIFO model.
// Define OKB_TIMEOUT_EN to also exercise the stall-timeout abort (TIMEOUT=8).
module tb_soc_system_ok_burst_reader;

`ifdef OKB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 1024;
`endif

    logic        clk;
    logic        reset_n;
    logic        ok_in;
    logic [31:0] fifo_q;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        done;

    soc_system_ok_burst_reader #(
        .DATA_W    (32),
        .BURST_LEN (16),
        .CNT_W     (16),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ok_in      (ok_in),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .st_data    (st_data),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Show-ahead FIFO model.
    logic [31:0] fmem [0:255];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic        hold_empty;

    assign fifo_empty = hold_empty || (rd_ptr == wr_ptr);
    assign fifo_q     = fmem[rd_ptr[7:0]];

    always @(posedge clk) if (fifo_rdreq) rd_ptr <= rd_ptr + 1;

    // Beat recorder and hold-stability monitor.
    logic [31:0] beats [0:255];
    int unsigned nbeats   = 0;
    int unsigned stab_err = 0;
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_rn = 1'b0;
    logic [31:0] prev_d = '0;

    always @(posedge clk) begin
        if (reset_n && st_valid && st_ready) begin
            beats[nbeats[7:0]] <= st_data;
            nbeats <= nbeats + 1;
        end
        if (reset_n && prev_rn && prev_v && !prev_r && (!st_valid || st_data !== prev_d))
            stab_err <= stab_err + 1;
        prev_v  <= st_valid;
        prev_r  <= st_ready;
        prev_d  <= st_data;
        prev_rn <= reset_n;
    end

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
        address = a;
        #1;
        v = readdata;
    endtask

    task automatic load_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wr_ptr[7:0]] = base + 32'(i);
            wr_ptr++;
        end
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    task automatic check_burst(input string tag, input int unsigned first, input logic [31:0] base);
        for (int i = 0; i < 16; i++)
            check_eq($sformatf("%s_w%0d", tag, i), beats[(first + 32'(i)) & 32'hff], base + 32'(i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int          cyc;
        int unsigned b0, nb_mid, bad, rp;

        reset_n    = 1'b0;
        ok_in      = 1'b0;
        st_ready   = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        hold_empty = 1'b0;
        tick(3);

        // Reset state
        check_eq("rst_valid", 32'(st_valid), 0);
        check_eq("rst_data", st_data, 0);
        check_eq("rst_rdreq", 32'(fifo_rdreq), 0);
        check_eq("rst_done", 32'(done), 0);
        rd_reg(2'd0, v); check_eq("rst_reg0", v, 0);
        rd_reg(2'd1, v); check_eq("rst_reg1", v, 0);
        rd_reg(2'd2, v); check_eq("rst_reg2", v, 16);
        rd_reg(2'd3, v); check_eq("rst_reg3", v, 0);

        load_words(32'hA000, 16);
        reset_n = 1'b1;
        tick(2);
        check_eq("idle_no_pop", 32'(fifo_rdreq), 0);

        // 1: full-throughput burst, done the cycle after the 16th accept
        ok_in = 1'b1;
        b0 = nbeats;
        wait_done(100, cyc);
        check_eq("t1_done", 32'(done), 1);
        check_eq("t1_latency", 32'(cyc), 18);
        check_eq("t1_beats", nbeats - b0, 16);
        check_burst("t1", b0, 32'hA000);
        rd_reg(2'd1, v); check_eq("t1_reg1", v, 16);
        rd_reg(2'd0, v); check_eq("t1_reg0", v, 32'h2);
        check_eq("t1_pops", rd_ptr, 16);

        // 4: ok held high in DONE does not re-trigger; a fresh edge does
        load_words(32'hB000, 16);
        tick(10);
        check_eq("t4_hold_done", 32'(done), 1);
        check_eq("t4_hold_rdreq", 32'(fifo_rdreq), 0);
        check_eq("t4_hold_pops", rd_ptr, 16);
        ok_in = 1'b0;
        tick();
        check_eq("t4_exit_done", 32'(done), 0);
        rd_reg(2'd1, v); check_eq("t4_reg1_kept", v, 16);
        ok_in = 1'b1;
        b0 = nbeats;
        wait_done(100, cyc);
        check_eq("t4_latency", 32'(cyc), 18);
        check_eq("t4_beats", nbeats - b0, 16);
        check_burst("t4", b0, 32'hB000);

        // 2: st_ready pattern 1,0,0,1 with backpressure
        ok_in = 1'b0;
        tick();
        load_words(32'hC000, 16);
        ok_in = 1'b1;
        b0 = nbeats;
        cyc = 0;
        while (!done && cyc < 400) begin
            st_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            tick();
            cyc++;
        end
        st_ready = 1'b1;
        check_eq("t2_done", 32'(done), 1);
        check_eq("t2_beats", nbeats - b0, 16);
        check_burst("t2", b0, 32'hC000);
        check_eq("t2_stable", stab_err, 0);
        check_eq("t2_pops", rd_ptr, 48);

        // 3: FIFO empty for 20 cycles mid-burst
        ok_in = 1'b0;
        tick();
        load_words(32'hD000, 16);
        ok_in = 1'b1;
        b0 = nbeats;
        tick(6);
        hold_empty = 1'b1;
        tick(2);
        nb_mid = nbeats;
        bad = 0;
        repeat (20) begin
            if (fifo_rdreq) bad++;
            tick();
        end
        check_eq("t3_no_pop", bad, 0);
        check_eq("t3_stalled", nbeats, nb_mid);
        check_eq("t3_valid_low", 32'(st_valid), 0);
        check_eq("t3_busy", 32'(done), 0);
        hold_empty = 1'b0;
        wait_done(100, cyc);
        check_eq("t3_done", 32'(done), 1);
        check_eq("t3_beats", nbeats - b0, 16);
        check_burst("t3", b0, 32'hD000);
        check_eq("t3_pops", rd_ptr, 64);

        // Soft re-arm; writes elsewhere are ignored
        ok_in = 1'b0;
        tick();
        load_words(32'hE000, 16);
        ok_in = 1'b1;
        wait_done(100, cyc);
        check_eq("rearm_done", 32'(done), 1);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = 32'h1;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
        check_eq("wr_ignored", 32'(done), 1);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'h1;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        check_eq("rearm_cleared", 32'(done), 0);
        rd_reg(2'd1, v); check_eq("rearm_reg1", v, 0);
        b0 = nbeats;
        tick(5);
        check_eq("rearm_no_burst", nbeats - b0, 0);
        rd_reg(2'd0, v); check_eq("rearm_reg0", v, 0);
        check_eq("rearm_pops", rd_ptr, 80);

`ifdef OKB_TIMEOUT_EN
        // 6: only 3 words available, abort after 8 stall cycles
        ok_in = 1'b0;
        tick();
        load_words(32'hF000, 3);
        ok_in = 1'b1;
        b0 = nbeats;
        wait_done(100, cyc);
        check_eq("t6_latency", 32'(cyc), 13);
        rd_reg(2'd0, v); check_eq("t6_reg0", v, 32'h6);
        rd_reg(2'd1, v); check_eq("t6_reg1", v, 3);
        check_eq("t6_beats", nbeats - b0, 3);
        ok_in = 1'b0;
        tick();
        rd_reg(2'd0, v); check_eq("t6_idle_reg0", v, 32'h4);
`endif

        // 5: reset at beat 7 abandons the burst
        ok_in = 1'b0;
        tick();
        load_words(32'h5000, 16);
        ok_in = 1'b1;
        b0 = nbeats;
        cyc = 0;
        while ((nbeats - b0) < 7 && cyc < 100) begin
            tick();
            cyc++;
        end
        check_eq("t5_reach7", nbeats - b0, 7);
        reset_n = 1'b0;
        ok_in = 1'b0;
        rp = rd_ptr;
        #1;
        check_eq("t5_rdreq_gated", 32'(fifo_rdreq), 0);
        tick();
        check_eq("t5_valid", 32'(st_valid), 0);
        check_eq("t5_data", st_data, 0);
        check_eq("t5_rdreq", 32'(fifo_rdreq), 0);
        check_eq("t5_done", 32'(done), 0);
        rd_reg(2'd1, v); check_eq("t5_reg1", v, 0);
        rd_reg(2'd0, v); check_eq("t5_reg0", v, 0);
        tick(3);
        reset_n = 1'b1;
        tick(5);
        check_eq("t5_no_more_pops", rd_ptr, rp);
        check_eq("t5_valid_after", 32'(st_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
